// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out converter for the AES-over-UART path.
// Takes one DATA_W-bit block over a valid/ready handshake and emits it as
// SYM_W-bit symbols with backpressure, selectable order, a per-block symbol
// count and an end-of-block marker.
// Optional feature: define PISO_DBUF_EN to add a one-entry holding buffer
// that lets the next block be accepted while the current one is shifting.
//
// state   | meaning
// S_IDLE  | nothing in flight, ready for a block
// S_SHIFT | out_data holds a valid symbol of the current block
module piso_stream #(
  parameter  int DATA_W = 128,
  parameter  int SYM_W  = 8,
  localparam int NSYM   = DATA_W / SYM_W,
  localparam int CNT_W  = $clog2(NSYM + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_len,
  input  logic              in_msb_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_data,
  output logic              out_last,
  output logic              empty
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam logic [CNT_W-1:0] NSYM_C = CNT_W'(NSYM);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C  = CNT_W'(2);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                msb_q, msb_d;
  logic [SYM_W-1:0]    dout_q, dout_d;
  logic                last_q, last_d;

  logic                accept;
  logic                xfer;
  logic                xfer_last;
  logic [CNT_W-1:0]    in_len_eff;

  // Load-path selection: which block (if any) enters the shifter this cycle.
  logic                ld_en;
  logic [DATA_W-1:0]   ld_data;
  logic [CNT_W-1:0]    ld_len;
  logic                ld_msb;
  logic [DATA_W-1:0]   shifted;

  function automatic logic [SYM_W-1:0] first_sym(input logic [DATA_W-1:0] d,
                                                 input logic m);
    return m ? d[DATA_W-1 -: SYM_W] : d[SYM_W-1:0];
  endfunction

  // Zero and oversize lengths both mean a full block.
  assign in_len_eff = (in_len == '0 || in_len > NSYM_C) ? NSYM_C : in_len;

  assign out_valid = (state_q == S_SHIFT);
  assign out_data  = dout_q;
  assign out_last  = last_q;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign xfer_last = xfer && (cnt_q == ONE_C);

`ifdef PISO_DBUF_EN
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]  hold_len_q, hold_len_d;
  logic              hold_msb_q, hold_msb_d;

  assign in_ready = !hold_full_q;
  assign empty    = (state_q == S_IDLE) && !hold_full_q;

  // Holding buffer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_len_q  <= '0;
      hold_msb_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      hold_msb_q  <= hold_msb_d;
    end
  end
`else
  assign in_ready = (state_q == S_IDLE);
  assign empty    = (state_q == S_IDLE);
`endif

  // Next-state logic: accept, shift on transfer, reload or idle after last.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    dout_d  = dout_q;
    last_d  = last_q;
    ld_en   = 1'b0;
    ld_data = in_data;
    ld_len  = in_len_eff;
    ld_msb  = in_msb_first;
    shifted = msb_q ? (sreg_q << SYM_W) : (sreg_q >> SYM_W);
`ifdef PISO_DBUF_EN
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    hold_msb_d  = hold_msb_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Hold is always empty here, so an IDLE accept goes straight in.
        if (accept) ld_en = 1'b1;
      end
      S_SHIFT: begin
        if (xfer && !xfer_last) begin
          sreg_d = shifted;
          dout_d = first_sym(shifted, msb_q);
          cnt_d  = cnt_q - ONE_C;
          last_d = (cnt_q == TWO_C);
        end else if (xfer_last) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
          cnt_d   = '0;
`ifdef PISO_DBUF_EN
          if (hold_full_q) begin
            ld_en       = 1'b1;
            ld_data     = hold_data_q;
            ld_len      = hold_len_q;
            ld_msb      = hold_msb_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            ld_en = 1'b1;
          end
`endif
        end
`ifdef PISO_DBUF_EN
        // An accept that did not go straight into the shifter parks in hold.
        if (accept && !xfer_last) begin
          hold_full_d = 1'b1;
          hold_data_d = in_data;
          hold_len_d  = in_len_eff;
          hold_msb_d  = in_msb_first;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (ld_en) begin
      state_d = S_SHIFT;
      sreg_d  = ld_data;
      cnt_d   = ld_len;
      msb_d   = ld_msb;
      dout_d  = first_sym(ld_data, ld_msb);
      last_d  = (ld_len == ONE_C);
    end
  end

  // Shifter and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      dout_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed self-checking bench for piso_stream (default parameters).
module tb_piso_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [4:0]   in_len;
  logic         in_msb_first;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         empty;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got_sym[$];
  logic       got_last[$];
  int         got_cycles;
  int         stall_err;
  int         rdy_err;

  localparam logic [127:0] BLK = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [4:0]   PAT = 5'b01001; // bit k = out_ready in cycle k mod 5: 1,0,0,1,0

  piso_stream dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_len       (in_len),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block and return just after the edge that accepted it.
  task automatic offer(input logic [127:0] d, input logic [4:0] len, input logic msb);
    int w = 0;
    in_valid     = 1'b1;
    in_data      = d;
    in_len       = len;
    in_msb_first = msb;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL offer_timeout in_ready=%0b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Drain one block; mode 0 = always ready, 1 = ready pattern.
  // poke offers junk blocks while shifting to probe in_ready.
  task automatic collect(input int mode, input bit poke);
    int   cyc = 0;
    bit   done = 0;
    bit   prev_stall = 0;
    logic [7:0] prev = '0;
    got_sym.delete();
    got_last.delete();
    stall_err = 0;
    rdy_err   = 0;
    while (!done && cyc < 300) begin
      out_ready = (mode == 0) ? 1'b1 : PAT[cyc % 5];
      if (prev_stall && out_data !== prev) stall_err++;
      if (poke && out_valid && in_ready) rdy_err++;
      in_valid = poke && out_valid && !(out_ready && out_last);
      in_data  = ~BLK;
      in_len   = 5'd1;
      if (out_valid && out_ready) begin
        got_sym.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last) done = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev       = out_data;
      tick();
      cyc++;
    end
    got_cycles = cyc;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL collect_timeout symbols=%0d no last seen", got_sym.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_len = '0; in_msb_first = 1'b1; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk); reset = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last got=%0b exp=0", out_last); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_msb_first();
    offer(BLK, 5'd0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL msb_latency out_valid=%0b exp=1", out_valid); end
    collect(0, 0);
    n_cmp++; if (got_sym.size() != 16) begin n_err++; $display("FAIL msb_count got=%0d exp=16", got_sym.size()); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_sym[i] !== 8'(i * 17)) begin n_err++; $display("FAIL msb_sym[%0d] got=%h exp=%h", i, got_sym[i], 8'(i * 17)); end
      n_cmp++; if (got_last[i] !== (i == 15)) begin n_err++; $display("FAIL msb_last[%0d] got=%0b exp=%0b", i, got_last[i], (i == 15)); end
    end
    n_cmp++; if (got_cycles != 16) begin n_err++; $display("FAIL msb_cycles got=%0d exp=16", got_cycles); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL msb_empty_after got=%0b exp=1", empty); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL msb_ready_after got=%0b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL msb_valid_after got=%0b exp=0", out_valid); end
  endtask

  task automatic test_lsb_first();
    offer(BLK, 5'd0, 1'b0);
    collect(0, 0);
    n_cmp++; if (got_sym.size() != 16) begin n_err++; $display("FAIL lsb_count got=%0d exp=16", got_sym.size()); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_sym[i] !== 8'((15 - i) * 17)) begin n_err++; $display("FAIL lsb_sym[%0d] got=%h exp=%h", i, got_sym[i], 8'((15 - i) * 17)); end
      n_cmp++; if (got_last[i] !== (i == 15)) begin n_err++; $display("FAIL lsb_last[%0d] got=%0b exp=%0b", i, got_last[i], (i == 15)); end
    end
  endtask

  task automatic test_length();
    offer(BLK, 5'd3, 1'b1);
    collect(0, 0);
    n_cmp++; if (got_sym.size() != 3) begin n_err++; $display("FAIL len3_count got=%0d exp=3", got_sym.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (got_sym[i] !== 8'(i * 17)) begin n_err++; $display("FAIL len3_sym[%0d] got=%h exp=%h", i, got_sym[i], 8'(i * 17)); end
      n_cmp++; if (got_last[i] !== (i == 2)) begin n_err++; $display("FAIL len3_last[%0d] got=%0b exp=%0b", i, got_last[i], (i == 2)); end
    end
    offer(BLK, 5'd20, 1'b1);
    collect(0, 0);
    n_cmp++; if (got_sym.size() != 16) begin n_err++; $display("FAIL len20_count got=%0d exp=16", got_sym.size()); end
    n_cmp++; if (got_sym[15] !== 8'hFF) begin n_err++; $display("FAIL len20_final got=%h exp=ff", got_sym[15]); end
    offer(BLK, 5'd1, 1'b0);
    collect(0, 0);
    n_cmp++; if (got_sym.size() != 1) begin n_err++; $display("FAIL len1_count got=%0d exp=1", got_sym.size()); end
    n_cmp++; if (got_sym[0] !== 8'hFF) begin n_err++; $display("FAIL len1_sym got=%h exp=ff", got_sym[0]); end
    n_cmp++; if (got_last[0] !== 1'b1) begin n_err++; $display("FAIL len1_last got=%0b exp=1", got_last[0]); end
  endtask

  task automatic test_backpressure();
    offer(BLK, 5'd0, 1'b1);
`ifdef PISO_DBUF_EN
    collect(1, 0);
`else
    collect(1, 1);
    n_cmp++; if (rdy_err != 0) begin n_err++; $display("FAIL bp_in_ready_in_shift got=%0d exp=0", rdy_err); end
`endif
    n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    n_cmp++; if (got_sym.size() != 16) begin n_err++; $display("FAIL bp_count got=%0d exp=16", got_sym.size()); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (got_sym[i] !== 8'(i * 17)) begin n_err++; $display("FAIL bp_sym[%0d] got=%h exp=%h", i, got_sym[i], 8'(i * 17)); end
    end
    n_cmp++; if (got_cycles <= 16) begin n_err++; $display("FAIL bp_cycles got=%0d exp>16", got_cycles); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_extra_block out_valid=%0b exp=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    offer(BLK, 5'd0, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_data !== 8'(i * 17) || out_valid !== 1'b1) begin n_err++; $display("FAIL mr_sym[%0d] got=%h v=%0b exp=%h", i, out_data, out_valid, 8'(i * 17)); end
      tick();
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_out_valid got=%0b exp=0", out_valid); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mr_empty got=%0b exp=1", empty); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_quiet[%0d] out_valid=%0b exp=0", i, out_valid); end
    end
    offer(BLK, 5'd2, 1'b0);
    collect(0, 0);
    n_cmp++; if (got_sym.size() != 2) begin n_err++; $display("FAIL mr_new_count got=%0d exp=2", got_sym.size()); end
    n_cmp++; if (got_sym[0] !== 8'hFF) begin n_err++; $display("FAIL mr_new_sym0 got=%h exp=ff", got_sym[0]); end
    n_cmp++; if (got_sym[1] !== 8'hEE || got_last[1] !== 1'b1) begin n_err++; $display("FAIL mr_new_sym1 got=%h last=%0b exp=ee last=1", got_sym[1], got_last[1]); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int nvalid = 0;
    int first_v = -1;
    int last_v = -1;
    int exp_span;
    bit acc;
    got_sym.delete();
    got_last.delete();
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_data      = BLK;
    in_len       = 5'd0;
    in_msb_first = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
        got_sym.push_back(out_data);
        got_last.push_back(out_last);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent == 2) in_valid = 1'b0;
        else in_msb_first = 1'b0;
      end
    end
`ifdef PISO_DBUF_EN
    exp_span = 32;
`else
    exp_span = 33;
`endif
    n_cmp++; if (nvalid != 32) begin n_err++; $display("FAIL b2b_valid_cycles got=%0d exp=32", nvalid); end
    n_cmp++; if (last_v - first_v + 1 != exp_span) begin n_err++; $display("FAIL b2b_span got=%0d exp=%0d", last_v - first_v + 1, exp_span); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (got_sym[i] !== ((i < 16) ? 8'(i * 17) : 8'((31 - i) * 17)) || got_last[i] !== (i == 15 || i == 31)) begin
        n_err++;
        $display("FAIL b2b_sym[%0d] got=%h last=%0b exp=%h last=%0b", i, got_sym[i], got_last[i],
                 (i < 16) ? 8'(i * 17) : 8'((31 - i) * 17), (i == 15 || i == 31));
      end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty_after got=%0b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_length();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out converter for the AES-over-UART datapath.
- Accepts one DATA_W-bit block, such as an AES ciphertext, over a valid/ready handshake.
- Emits it as a stream of SYM_W-bit symbols toward the UART transmitter, with output backpressure.
- Supports a selectable symbol order, a variable symbol count per block, and an end-of-block marker.

Parameters:
- DATA_W, 128: parallel block width in bits; must be an integer multiple of SYM_W.
- SYM_W, 8: serial symbol width in bits.
- NSYM, DATA_W/SYM_W: symbols per block. Derived; not overridden.
- CNT_W, $clog2(NSYM+1): width of the length and count fields. Derived.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  block offered.
- in_ready  out  1  block can be accepted.
- in_data  in  DATA_W  parallel block.
- in_len  in  CNT_W  number of symbols to send. 0 means NSYM; values above NSYM are clamped to NSYM.
- in_msb_first  in  1  1: first symbol is in_data[DATA_W-1 -: SYM_W]. 0: first symbol is in_data[SYM_W-1:0].
- out_valid  out  1  out_data holds a valid symbol.
- out_ready  in  1  sink accepts the symbol.
- out_data  out  SYM_W  current symbol.
- out_last  out  1  current symbol is the final symbol of its block.
- empty  out  1  no block is held or in flight.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, empty=1, shift register=0, count=0, state=IDLE.
- Reset asserted mid-block discards the block; no symbols are emitted after reset release until a new accept.
- Transfers:
  - Accept occurs on in_valid && in_ready at a clk edge.
  - Symbol transfer occurs on out_valid && out_ready at a clk edge.
- State machine, two states:
  - IDLE: in_ready=1, out_valid=0, empty=1.
    - On accept: latch in_data, the effective length L (1..NSYM) and in_msb_first.
    - out_data is loaded with the first symbol; out_valid and out_last are registered.
    - Go to SHIFT.
    - out_valid rises the cycle after accept, giving 1-cycle latency.
  - SHIFT: out_valid=1, in_ready=0 (without the optional feature), empty=0.
    - On a symbol transfer that is not the last: shift by SYM_W toward the emitted end (left if MSB-first, right if LSB-first, zero fill).
    - Register the next symbol into out_data and decrement the remaining count.
    - out_last=1 exactly when remaining count == 1.
    - On transfer of the last symbol: out_valid=0, out_last=0, return to IDLE, in_ready=1 in the next cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_last and internal state hold stable indefinitely.
- L=1: a single symbol is emitted, with out_last=1 on it.
- Latched in_msb_first and L apply to the whole block. Input port changes after accept have no effect.
- Throughput without the optional feature: L transfer cycles plus 1 bubble cycle per block.

Optional Feature:
- Macro: PISO_DBUF_EN
- Defined: adds a one-entry holding buffer for the next block (data, L, order bit).
  - in_ready = !hold_full, so a block can be accepted during SHIFT.
  - On last-symbol transfer with hold_full=1: the held block loads directly, and out_data presents its first symbol in the next cycle. out_valid stays 1, giving zero bubble.
  - If the last-symbol transfer and an accept coincide with hold empty: the incoming block loads directly into the shifter, also with zero bubble.
  - Accept in IDLE bypasses the hold buffer.
  - empty=1 only when IDLE and hold empty.
  - Reset clears hold_full.
- Undefined: no holding buffer. in_ready is high only in IDLE, and behaviour is as above.

Test Plan:
- Defaults; in_data=0x00112233445566778899AABBCCDDEEFF, in_len=0, msb_first=1, out_ready=1 -> 16 consecutive symbols 0x00,0x11,...,0xFF starting 1 cycle after accept; out_last only on 0xFF; then empty=1 and in_ready=1.
- Same data, msb_first=0 -> symbols 0xFF,0xEE,...,0x00; out_last on 0x00.
- Same data, in_len=3, msb_first=1 -> 0x00,0x11,0x22 with out_last on 0x22. Also in_len=20 -> clamped, 16 symbols.
- out_ready pattern 1,0,0,1,0,1,... -> no symbol dropped or duplicated; out_data stable while stalled; in_valid ignored (in_ready=0) during SHIFT without PISO_DBUF_EN.
- Assert reset after the 5th symbol transfer (0x44 emitted) -> out_valid=0, empty=1, in_ready=1 immediately. A new block afterwards starts from its first symbol.
- With PISO_DBUF_EN, two blocks offered back-to-back with out_ready=1 -> 32 consecutive out_valid cycles, with out_last on cycles 16 and 32 and no bubble. Without the macro -> one bubble cycle between the blocks.
